expr_result_checker: RTL and testbench

// - Consumer end of the packed 90-bit expression result bus {y0..y17} (y0 at MSB) driven by the expression_* DUTs.
// - Buffers golden vectors in a FIFO and pairs each with a DUT result over valid/ready.
// - Splits both vectors into the 18 fields, compares them per field, reports a mismatch mask and keeps counters.
// - Sits between the regression stimulus engine and the pass/fail reporting logic.

---
 rtl/expr_chk_pkg.sv | 17 +
 rtl/expr_chk_fifo.sv | 32 +++
 rtl/expr_result_checker.sv | 97 +++++++++
 tb/tb_expr_result_checker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/expr_chk_pkg.sv
// expr_chk_pkg: field map of the 90-bit expression result bus {y0..y17}, y0 at MSB.
package expr_chk_pkg;
   localparam int NFIELDS = 18;
   localparam int YW = 90;
   localparam int FIELD_W [NFIELDS] = '{4,5,6, 4,5,6, 4,5,6, 4,5,6, 4,5,6, 4,5,6};
   localparam int FIELD_LSB [NFIELDS] = '{86,81,75, 71,66,60, 56,51,45, 41,36,30, 26,21,15, 11,6,0};
   localparam bit FIELD_SIGNED [NFIELDS] = '{0,0,0, 1,1,1, 0,0,0, 1,1,1, 0,0,0, 1,1,1};
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   function automatic logic [5:0] field_ext(input logic [YW-1:0] v, input int k);
      logic [5:0] msk;
      logic [5:0] r;
      msk = 6'((1 << FIELD_W[k]) - 1);
      r = 6'(v >> FIELD_LSB[k]) & msk;
      if (FIELD_SIGNED[k] && r[FIELD_W[k]-1]) r = r | ~msk;
      return r;
   endfunction
endpackage

// File: rtl/expr_chk_fifo.sv
// expr_chk_fifo: synchronous FIFO holding golden vectors, with full/empty flags.
module expr_chk_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 90
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   assign dout = mem[rp[AW-1:0]];
   assign empty = wp == rp;
   assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   always_ff @(posedge clk)
      if (push) mem[wp[AW-1:0]] <= din;
   always_ff @(posedge clk) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
      end
   end
endmodule

// File: rtl/expr_result_checker.sv
// expr_result_checker: pairs golden and DUT result vectors, compares them per field, counts errors.
// Optional first-mismatch decode (bad_*) enabled by EXPR_CHK_FIELD_DECODE_EN.
module expr_result_checker
   import expr_chk_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16,
   parameter int STOP_ON_ERR = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [17:0]        field_en,
   input  logic               exp_valid,
   output logic               exp_ready,
   input  logic [89:0]        exp_y,
   input  logic               dut_valid,
   output logic               dut_ready,
   input  logic [89:0]        dut_y,
   output logic               res_valid,
   output logic [17:0]        res_mask,
   output logic [CNT_W-1:0]   vec_cnt,
   output logic [CNT_W-1:0]   err_cnt,
   output logic               halted,
   output logic [4:0]         bad_field,
   output logic [5:0]         bad_got,
   output logic [5:0]         bad_exp
);
   state_t state, state_n;
   logic [YW-1:0] head;
   logic full, empty, fire, err_hit;
   logic [NFIELDS-1:0] mask_c;
   assign exp_ready = ~full;
   assign dut_ready = (state == RUN) && ~empty;
   assign fire = dut_valid && dut_ready;
   assign halted = state == HALT;
   assign err_hit = fire && (|mask_c);
   expr_chk_fifo #(.DEPTH(DEPTH), .W(YW)) u_fifo (
      .clk(clk), .reset(reset), .push(exp_valid && exp_ready), .din(exp_y),
      .pop(fire), .dout(head), .full(full), .empty(empty)
   );
   // mask bit 17-k carries field yk, following the bus packing with y0 at the MSB
   always_comb begin
      mask_c = '0;
      for (int k = 0; k < NFIELDS; k++)
         mask_c[NFIELDS-1-k] = field_en[NFIELDS-1-k] && (field_ext(dut_y, k) != field_ext(head, k));
   end
   always_comb begin
      state_n = (state == RUN) ? ((STOP_ON_ERR != 0 && err_hit) ? HALT : RUN) : (start ? RUN : state);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         res_valid <= 1'b0;
         res_mask <= '0;
         vec_cnt <= '0;
         err_cnt <= '0;
      end else begin
         state <= state_n;
         res_valid <= fire;
         if (fire) res_mask <= mask_c;
         vec_cnt <= start ? CNT_W'(fire) : vec_cnt + CNT_W'(fire);
         err_cnt <= start ? CNT_W'(err_hit) : (err_hit && ~&err_cnt) ? err_cnt + CNT_W'(1) : err_cnt;
      end
   end
`ifdef EXPR_CHK_FIELD_DECODE_EN
   logic [4:0] bf_n;
   logic [5:0] bg_n, be_n;
   // descending scan so the lowest mismatching k wins
   always_comb begin
      bf_n = '0;
      bg_n = '0;
      be_n = '0;
      for (int k = NFIELDS - 1; k >= 0; k--)
         if (mask_c[NFIELDS-1-k]) begin
            bf_n = 5'(k);
            bg_n = field_ext(dut_y, k);
            be_n = field_ext(head, k);
         end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         bad_field <= '0;
         bad_got <= '0;
         bad_exp <= '0;
      end else if (err_hit) begin
         bad_field <= bf_n;
         bad_got <= bg_n;
         bad_exp <= be_n;
      end
   end
`else
   assign bad_field = '0;
   assign bad_got = '0;
   assign bad_exp = '0;
`endif
endmodule

// File: tb/tb_expr_result_checker.sv
// tb_expr_result_checker: directed and random stimulus against a transaction-level reference model.
module tb_expr_result_checker;
   localparam int DEPTH = 4;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, exp_valid = 1'b0, dut_valid = 1'b0;
   logic [17:0] field_en = '1;
   logic [89:0] exp_y = '0, dut_y = '0;
   logic exp_ready, dut_ready, res_valid, halted;
   logic [17:0] res_mask;
   logic [15:0] vec_cnt, err_cnt;
   logic [4:0] bad_field;
   logic [5:0] bad_got, bad_exp;
   int n_chk = 0, n_bad = 0;
   logic [89:0] m_q [$];
   int m_st;
   logic [15:0] m_vec, m_err;
   logic m_rv;
   logic [17:0] m_rm;
   logic [4:0] m_bf;
   logic [5:0] m_bg, m_be;
   always #5 clk = ~clk;
   expr_result_checker #(.DEPTH(DEPTH), .CNT_W(16), .STOP_ON_ERR(1)) dut (
      .clk(clk), .reset(reset), .start(start), .field_en(field_en),
      .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_y(exp_y),
      .dut_valid(dut_valid), .dut_ready(dut_ready), .dut_y(dut_y),
      .res_valid(res_valid), .res_mask(res_mask), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
      .halted(halted), .bad_field(bad_field), .bad_got(bad_got), .bad_exp(bad_exp)
   );
   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic int fw(input int k);
      return 4 + k % 3;
   endfunction
   function automatic int flsb(input int k);
      return 90 - 15 * (k / 3) - ((k % 3 == 0) ? 4 : (k % 3 == 1) ? 9 : 15);
   endfunction
   function automatic logic [5:0] fget(input logic [89:0] v, input int k, input bit sx);
      int val;
      val = int'((v >> flsb(k)) & ((90'(1) << fw(k)) - 1));
      if (sx && (k / 3) % 2 == 1 && val >= (1 << (fw(k) - 1))) val -= (1 << fw(k));
      return 6'(val);
   endfunction
   function automatic logic [89:0] fset(input logic [89:0] v, input int k, input int val);
      logic [89:0] m;
      m = ((90'(1) << fw(k)) - 1) << flsb(k);
      return (v & ~m) | ((90'(val) << flsb(k)) & m);
   endfunction
   function automatic logic [17:0] mmask(input logic [89:0] e, input logic [89:0] d, input logic [17:0] fe);
      logic [17:0] m;
      m = '0;
      for (int k = 0; k < 18; k++)
         if (fe[17-k] && fget(d, k, 0) != fget(e, k, 0)) m[17-k] = 1'b1;
      return m;
   endfunction
   function automatic logic [89:0] rnd90();
      return 90'({$urandom, $urandom, $urandom});
   endfunction
   task automatic model_reset();
      m_q.delete();
      m_st = 0;
      m_vec = '0;
      m_err = '0;
      m_rv = 1'b0;
      m_rm = '0;
      m_bf = '0;
      m_bg = '0;
      m_be = '0;
   endtask
   task automatic check_all();
      check("exp_ready", exp_ready, m_q.size() < DEPTH);
      check("dut_ready", dut_ready, m_st == 1 && m_q.size() > 0);
      check("res_valid", res_valid, m_rv);
      check("res_mask", res_mask, m_rm);
      check("vec_cnt", vec_cnt, m_vec);
      check("err_cnt", err_cnt, m_err);
      check("halted", halted, m_st == 2);
      check("bad_field", bad_field, m_bf);
      check("bad_got", bad_got, m_bg);
      check("bad_exp", bad_exp, m_be);
   endtask
   task automatic cyc(input bit st, input bit ev, input logic [89:0] ey, input bit dv,
                      input logic [89:0] dy, input logic [17:0] fe);
      bit push, fire;
      logic [17:0] m;
      logic [89:0] h;
      start = st; exp_valid = ev; exp_y = ey; dut_valid = dv; dut_y = dy; field_en = fe;
      push = ev && m_q.size() < DEPTH;
      fire = dv && m_st == 1 && m_q.size() > 0;
      h = fire ? m_q[0] : '0;
      m = fire ? mmask(h, dy, fe) : '0;
      @(posedge clk);
      if (reset) model_reset();
      else begin
         m_rv = fire;
         if (fire) m_rm = m;
         if (st) begin
            m_vec = 16'(fire);
            m_err = 16'(fire && m != 0);
         end else if (fire) begin
            m_vec++;
            if (m != 0 && m_err != 16'hFFFF) m_err++;
         end
         if (m_st == 1 && fire && m != 0) m_st = 2;
         else if (st) m_st = 1;
`ifdef EXPR_CHK_FIELD_DECODE_EN
         if (fire && m != 0)
            for (int k = 0; k < 18; k++)
               if (m[17-k]) begin
                  m_bf = 5'(k);
                  m_bg = fget(dy, k, 1);
                  m_be = fget(h, k, 1);
                  break;
               end
`endif
         if (fire) void'(m_q.pop_front());
         if (push) m_q.push_back(ey);
      end
      @(negedge clk);
      check_all();
   endtask
   task automatic fire_head(input logic [89:0] dy);
      cyc(0, 0, '0, 1, dy, '1);
   endtask
   initial begin
      logic [89:0] a, b, c, d, e2;
      logic [15:0] e_before;
      model_reset();
      reset = 1'b1;
      cyc(0, 0, '0, 0, '0, '1);
      cyc(0, 0, '0, 0, '0, '1);
      reset = 1'b0;
      check("rst_exp_ready", exp_ready, 1);
      check("rst_dut_ready", dut_ready, 0);
      check("rst_vec", vec_cnt, 0);
      check("rst_err", err_cnt, 0);
      a = rnd90();
      cyc(0, 1, a, 0, '0, '1);
      cyc(1, 0, '0, 0, '0, '1);
      fire_head(a);
      check("first_rv", res_valid, 1);
      check("first_mask", res_mask, 0);
      check("first_vec", vec_cnt, 1);
      check("first_err", err_cnt, 0);
      b = fset(rnd90(), 5, 1);
      cyc(0, 1, b, 0, '0, '1);
      fire_head(fset(b, 5, 63));
      check("y5_mask", res_mask, 18'h01000);
`ifdef EXPR_CHK_FIELD_DECODE_EN
      check("y5_field", bad_field, 5);
      check("y5_got", bad_got, 6'h3F);
      check("y5_exp", bad_exp, 6'h01);
`endif
      cyc(1, 0, '0, 0, '0, '1);
      c = fset(rnd90(), 3, 1);
      cyc(0, 1, c, 0, '0, '1);
      fire_head(fset(c, 3, 15));
`ifdef EXPR_CHK_FIELD_DECODE_EN
      check("y3_field", bad_field, 3);
      check("y3_got", bad_got, 6'h3F);
      check("y3_exp", bad_exp, 6'h01);
`endif
      cyc(1, 0, '0, 0, '0, '1);
      for (int i = 0; i < DEPTH; i++) cyc(0, 1, rnd90(), 0, '0, '1);
      check("full_exp_ready", exp_ready, 0);
      fire_head(m_q[0]);
      check("pop_exp_ready", exp_ready, 1);
      for (int i = 0; i < DEPTH - 1; i++) fire_head(m_q[0]);
      check("empty_dut_ready", dut_ready, 0);
      d = rnd90();
      cyc(0, 1, d, 0, '0, '1);
      e_before = m_err;
      cyc(0, 0, '0, 1, fset(d, 0, int'(fget(d, 0, 0) ^ 6'hF)), 18'h3FFFF ^ (18'd1 << 17));
      check("fe_mask", res_mask, 0);
      check("fe_err", err_cnt, e_before);
      cyc(1, 0, '0, 0, '0, '1);
      for (int i = 0; i < 3; i++) cyc(0, 1, rnd90(), 0, '0, '1);
      fire_head(m_q[0]);
      fire_head(m_q[0]);
      e2 = m_q[0];
      fire_head(fset(e2, 10, int'(fget(e2, 10, 0) ^ 6'h5)));
      check("stop_halted", halted, 1);
      check("stop_dut_ready", dut_ready, 0);
      check("stop_vec", vec_cnt, 3);
      check("stop_err", err_cnt, 1);
      cyc(1, 0, '0, 0, '0, '1);
      check("restart_halted", halted, 0);
      check("restart_vec", vec_cnt, 0);
      check("restart_err", err_cnt, 0);
      for (int i = 0; i < 1500; i++) begin
         bit st, ev, dv;
         logic [89:0] dy;
         logic [17:0] fe;
         int r;
         reset = ($urandom_range(0, 300) == 0);
         st = (m_st != 1 && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0;
         ev = 1'($urandom_range(0, 1));
         dv = $urandom_range(0, 2) != 0;
         dy = (m_q.size() > 0) ? m_q[0] : rnd90();
         r = $urandom_range(0, 5);
         if (r == 0) dy = fset(dy, $urandom_range(0, 17), int'($urandom_range(0, 63)));
         else if (r == 1) dy = dy ^ (90'(1) << $urandom_range(0, 89));
         fe = ($urandom_range(0, 7) == 0) ? 18'($urandom) : '1;
         cyc(st, ev, rnd90(), dv, dy, fe);
      end
      reset = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end
endmodule
